// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - operand-fetch front end: issues masked register reads and assembles operand bundles
module operand_collector #(
    parameter int NUM_OPS    = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CODE_W     = 8,
    parameter int META_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic [CODE_W-1:0]         uinstr_code_i,
    input  logic [NUM_OPS-1:0]        uinstr_mask_i,
    input  logic [NUM_OPS*ADDR_W-1:0] uinstr_addr_i,
    input  logic                      uinstr_valid_i,
    output logic                      uinstr_ready_o,
    output logic [ADDR_W-1:0]         rd_addr_o,
    output logic                      rd_addr_valid_o,
    input  logic                      rd_addr_ready_i,
    input  logic [DATA_W-1:0]         rd_data_i,
    input  logic                      rd_data_valid_i,
    output logic                      rd_data_ready_o,
    output logic [NUM_OPS*DATA_W-1:0] operands_o,
    output logic [NUM_OPS-1:0]        operand_mask_o,
    output logic [CODE_W-1:0]         operation_code_o,
    output logic                      operation_valid_o,
    input  logic                      operation_ready_i
);

    localparam int PTR_W = $clog2(META_DEPTH);
    localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run;
    logic [CODE_W-1:0]   r_meta_code [META_DEPTH];
    logic [NUM_OPS-1:0]  r_meta_mask [META_DEPTH];
    logic [PTR_W:0]      r_wr_ptr;
    logic [PTR_W:0]      r_rd_ptr;
    logic [ADDR_W-1:0]   r_addr [NUM_OPS];
    logic [NUM_OPS-1:0]  r_rem;
    logic [NUM_OPS-1:0]  r_rcv;
    logic [DATA_W-1:0]   r_opnd [NUM_OPS];

    logic                w_full;
    logic                w_head_valid;
    logic [NUM_OPS-1:0]  w_head_mask;
    logic [NUM_OPS-1:0]  w_pending;
    logic [NUM_OPS-1:0]  w_rem_low;
    logic [IDX_W-1:0]    w_issue_idx;
    logic [IDX_W-1:0]    w_data_idx;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_addr_hs;
    logic                w_data_hs;
    logic                w_pop;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_OPS-1:0] m);
        lowest_idx = '0;
        for (int k = NUM_OPS - 1; k >= 0; k--) begin
            if (m[k]) lowest_idx = IDX_W'(k);
        end
    endfunction

    assign w_full       = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_head_valid = (r_wr_ptr != r_rd_ptr);
    assign w_head_mask  = w_head_valid ? r_meta_mask[r_rd_ptr[PTR_W-1:0]] : '0;
    assign w_pending    = w_head_mask & ~r_rcv;
    assign w_rem_low    = r_rem & (-r_rem);
    assign w_issue_idx  = lowest_idx(r_rem);
    assign w_data_idx   = lowest_idx(w_pending);

    assign w_in_ready   = r_run && !w_full && (r_state == S_IDLE);
    assign w_accept     = uinstr_valid_i && w_in_ready;
    assign w_addr_hs    = rd_addr_valid_o && rd_addr_ready_i;
    assign w_data_hs    = rd_data_valid_i && rd_data_ready_o;
    assign w_pop        = operation_valid_o && operation_ready_i;

    assign uinstr_ready_o    = w_in_ready;
    assign rd_addr_o         = rd_addr_valid_o ? r_addr[w_issue_idx] : '0;
    assign rd_data_ready_o   = w_head_valid && (w_pending != '0);
    assign operation_valid_o = w_head_valid && (w_pending == '0);
    assign operand_mask_o    = w_head_mask;
    assign operation_code_o  = w_head_valid ? r_meta_code[r_rd_ptr[PTR_W-1:0]] : '0;

    // Out-of-reset flag holds off instruction acceptance until the first edge after release.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

    // Issue FSM state register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Issue FSM next state and read-request valid.
    always_comb begin
        w_state_nxt     = r_state;
        rd_addr_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (uinstr_mask_i != '0)) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                rd_addr_valid_o = 1'b1;
                if (rd_addr_ready_i && ((r_rem & ~w_rem_low) == '0)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch slot addresses on accept and retire one remaining-mask bit per address handshake.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rem <= '0;
            for (int k = 0; k < NUM_OPS; k++) r_addr[k] <= '0;
        end else if (w_accept) begin
            r_rem <= uinstr_mask_i;
            for (int k = 0; k < NUM_OPS; k++) r_addr[k] <= uinstr_addr_i[k*ADDR_W +: ADDR_W];
        end else if (w_addr_hs) begin
            r_rem <= r_rem & ~w_rem_low;
        end
    end

    // Metadata FIFO pointers: push on accept, pop on bundle handshake.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Metadata FIFO storage; contents are only observed through a valid head.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_meta_code[r_wr_ptr[PTR_W-1:0]] <= uinstr_code_i;
            r_meta_mask[r_wr_ptr[PTR_W-1:0]] <= uinstr_mask_i;
        end
    end

    // Collect in-order read data into the lowest pending slot; clear everything on retire.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rcv <= '0;
            for (int k = 0; k < NUM_OPS; k++) r_opnd[k] <= '0;
        end else if (w_pop) begin
            r_rcv <= '0;
            for (int k = 0; k < NUM_OPS; k++) r_opnd[k] <= '0;
        end else if (w_data_hs) begin
            r_rcv[w_data_idx]  <= 1'b1;
            r_opnd[w_data_idx] <= rd_data_i;
        end
    end

    // Pack operand registers onto the bundle bus.
    always_comb begin
        operands_o = '0;
        for (int k = 0; k < NUM_OPS; k++) operands_o[k*DATA_W +: DATA_W] = r_opnd[k];
    end

endmodule
